// File: rtl/move_link.sv
// Reliable move exchange over the UART tx/rx pair: sends moves that must be acked
// with their bitwise complement, retransmits on timeout, and delivers and acks peer moves.
module move_link #(
   parameter int PKT_LEN         = 8,
   parameter int TX_FRAME_CYCLES = 67_710,
   parameter int ACK_TIMEOUT     = 650_000,
   parameter int MAX_RETRY       = 3
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               send_valid,
   input  logic [PKT_LEN-1:0] send_data,
   output logic               send_busy,
   output logic               send_done,
   output logic               link_err,
   output logic               tx_trigger,
   output logic [PKT_LEN-1:0] tx_data,
   input  logic               rx_ready,
   input  logic [PKT_LEN-1:0] rx_data,
   output logic               move_valid,
   output logic [PKT_LEN-1:0] move_data
);

   localparam int CNT_W   = 20;
   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W-1:0]   FRAME_LAST  = CNT_W'(TX_FRAME_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LIM = CNT_W'(ACK_TIMEOUT);
   localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(MAX_RETRY);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_ACK,
      ACK
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   frame_cnt;
   logic [CNT_W-1:0]   ack_timer;
   logic [RETRY_W-1:0] retry_cnt;
   logic [PKT_LEN-1:0] last_rx;
   logic               last_valid;
   logic               pend_valid;
   logic [PKT_LEN-1:0] pend_data;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] lim);
      return (v >= lim) ? lim : v + 1'b1;
   endfunction

   function automatic logic is_dup(input logic               have_last,
                                   input logic [PKT_LEN-1:0] prev,
                                   input logic [PKT_LEN-1:0] b);
      return have_last && (b == prev);
   endfunction

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= IDLE;
         frame_cnt  <= '0;
         ack_timer  <= '0;
         retry_cnt  <= '0;
         last_rx    <= '0;
         last_valid <= 1'b0;
         pend_valid <= 1'b0;
         pend_data  <= '0;
         send_busy  <= 1'b0;
         send_done  <= 1'b0;
         link_err   <= 1'b0;
         tx_trigger <= 1'b0;
         tx_data    <= '0;
         move_valid <= 1'b0;
         move_data  <= '0;
      end else begin
         tx_trigger <= 1'b0;
         send_done  <= 1'b0;
         move_valid <= 1'b0;

         case (state)
            IDLE: begin
               // Receive path has priority; a colliding send request waits until the ack is out.
               if (rx_ready) begin
                  if (send_valid) begin
                     pend_valid <= 1'b1;
                     pend_data  <= send_data;
                  end
                  if (!is_dup(last_valid, last_rx, rx_data)) begin
                     move_data  <= rx_data;
                     move_valid <= 1'b1;
                     last_rx    <= rx_data;
                     last_valid <= 1'b1;
                  end
                  tx_data    <= ~rx_data;
                  tx_trigger <= 1'b1;
                  frame_cnt  <= '0;
                  state      <= ACK;
               end else if (send_valid || pend_valid) begin
                  tx_data    <= send_valid ? send_data : pend_data;
                  pend_valid <= 1'b0;
                  tx_trigger <= 1'b1;
                  send_busy  <= 1'b1;
                  link_err   <= 1'b0;
                  retry_cnt  <= '0;
                  last_valid <= 1'b0;
                  frame_cnt  <= '0;
                  state      <= SEND;
               end
            end

            SEND: begin
               if (frame_cnt >= FRAME_LAST) begin
                  ack_timer <= '0;
                  state     <= WAIT_ACK;
               end else begin
                  frame_cnt <= sat_inc(frame_cnt, FRAME_LAST);
               end
            end

            WAIT_ACK: begin
               // Only the complement of the outstanding move counts; anything else is ignored.
               if (rx_ready && (rx_data == ~tx_data)) begin
                  send_done <= 1'b1;
                  send_busy <= 1'b0;
                  state     <= IDLE;
               end else if (ack_timer >= TIMEOUT_LIM) begin
                  if (retry_cnt < RETRY_LIM) begin
                     retry_cnt  <= retry_cnt + 1'b1;
                     tx_trigger <= 1'b1;
                     frame_cnt  <= '0;
                     state      <= SEND;
                  end else begin
                     link_err  <= 1'b1;
                     send_busy <= 1'b0;
                     state     <= IDLE;
                  end
               end else begin
                  ack_timer <= sat_inc(ack_timer, TIMEOUT_LIM);
               end
            end

            ACK: begin
               if (send_valid) begin
                  pend_valid <= 1'b1;
                  pend_data  <= send_data;
               end
               if (frame_cnt >= FRAME_LAST) begin
                  state <= IDLE;
               end else begin
                  frame_cnt <= sat_inc(frame_cnt, FRAME_LAST);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_move_link.sv
// Directed bench for move_link: expected tx triggers and deliveries are queued as
// stimulus is driven and matched by negedge monitors; status outputs are checked inline.
module tb_move_link;

   localparam int F = 20;
   localparam int A = 100;
   localparam int R = 2;
   localparam int PERIOD_GAP = F + A + 1;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       send_valid = 1'b0;
   logic [7:0] send_data = 8'h00;
   logic       send_busy;
   logic       send_done;
   logic       link_err;
   logic       tx_trigger;
   logic [7:0] tx_data;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       move_valid;
   logic [7:0] move_data;

   move_link #(
      .PKT_LEN(8),
      .TX_FRAME_CYCLES(F),
      .ACK_TIMEOUT(A),
      .MAX_RETRY(R)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .send_valid(send_valid),
      .send_data(send_data),
      .send_busy(send_busy),
      .send_done(send_done),
      .link_err(link_err),
      .tx_trigger(tx_trigger),
      .tx_data(tx_data),
      .rx_ready(rx_ready),
      .rx_data(rx_data),
      .move_valid(move_valid),
      .move_data(move_data)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t trig_q[$];
   exp_t move_q[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always @(posedge clk_in) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic push_trig(input logic [7:0] d, input int at);
      exp_t e;
      e.data = d;
      e.cyc  = at;
      trig_q.push_back(e);
   endtask

   task automatic push_move(input logic [7:0] d, input int at);
      exp_t e;
      e.data = d;
      e.cyc  = at;
      move_q.push_back(e);
   endtask

   // Trigger monitor: every pulse must match the queue head in cycle and data.
   always @(negedge clk_in) begin
      logic due;
      exp_t e;
      due = (trig_q.size() > 0) && (trig_q[0].cyc == cyc);
      if (tx_trigger || due) begin
         chk("trig_pulse", {31'd0, tx_trigger}, {31'd0, due});
         if (due) begin
            e = trig_q.pop_front();
            if (tx_trigger) chk("trig_data", {24'd0, tx_data}, {24'd0, e.data});
         end
      end
   end

   always @(negedge clk_in) begin
      logic due;
      exp_t e;
      due = (move_q.size() > 0) && (move_q[0].cyc == cyc);
      if (move_valid || due) begin
         chk("move_pulse", {31'd0, move_valid}, {31'd0, due});
         if (due) begin
            e = move_q.pop_front();
            if (move_valid) chk("move_data", {24'd0, move_data}, {24'd0, e.data});
         end
      end
   end

   initial begin
      int t;

      // Reset state
      step(3);
      chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
      chk("rst_move_data", {24'd0, move_data}, 32'h00);
      chk("rst_flags", {28'd0, send_busy, send_done, link_err, move_valid}, 32'h0);
      rst_in = 1'b0;
      step(2);

      // Send 3C, acked with C3
      send_valid = 1'b1;
      send_data  = 8'h3C;
      push_trig(8'h3C, cyc + 1);
      step(1);
      send_valid = 1'b0;
      chk("t1_busy", {31'd0, send_busy}, 32'd1);
      step(25);
      rx_ready = 1'b1;
      rx_data  = 8'hC3;
      step(1);
      rx_ready = 1'b0;
      chk("t1_done", {31'd0, send_done}, 32'd1);
      chk("t1_busy_fall", {31'd0, send_busy}, 32'd0);
      step(1);
      chk("t1_done_once", {31'd0, send_done}, 32'd0);
      chk("t1_err", {31'd0, link_err}, 32'd0);

      // Send 12, no reply: three attempts then link_err
      send_valid = 1'b1;
      send_data  = 8'h12;
      t = cyc + 1;
      push_trig(8'h12, t);
      push_trig(8'h12, t + PERIOD_GAP);
      push_trig(8'h12, t + 2 * PERIOD_GAP);
      step(1);
      send_valid = 1'b0;
      step(3 * PERIOD_GAP - 1);
      chk("t2_err_early", {31'd0, link_err}, 32'd0);
      chk("t2_busy_hold", {31'd0, send_busy}, 32'd1);
      step(1);
      chk("t2_err", {31'd0, link_err}, 32'd1);
      chk("t2_busy_fall", {31'd0, send_busy}, 32'd0);
      step(2);

      // Receive 55, duplicate 55, local send, 55 again
      rx_ready = 1'b1;
      rx_data  = 8'h55;
      push_trig(8'hAA, cyc + 1);
      push_move(8'h55, cyc + 1);
      step(1);
      rx_ready = 1'b0;
      step(F);
      chk("t3_err_sticky", {31'd0, link_err}, 32'd1);
      rx_ready = 1'b1;
      rx_data  = 8'h55;
      push_trig(8'hAA, cyc + 1);
      step(1);
      rx_ready = 1'b0;
      step(F);
      chk("t3_move_hold", {24'd0, move_data}, 32'h55);
      send_valid = 1'b1;
      send_data  = 8'h5A;
      push_trig(8'h5A, cyc + 1);
      step(1);
      send_valid = 1'b0;
      chk("t3_err_clear", {31'd0, link_err}, 32'd0);
      step(F + 3);
      rx_ready = 1'b1;
      rx_data  = 8'hA5;
      step(1);
      rx_ready = 1'b0;
      chk("t3_done", {31'd0, send_done}, 32'd1);
      step(1);
      rx_ready = 1'b1;
      rx_data  = 8'h55;
      push_trig(8'hAA, cyc + 1);
      push_move(8'h55, cyc + 1);
      step(1);
      rx_ready = 1'b0;
      step(F);

      // Simultaneous send 0F and receive 70
      send_valid = 1'b1;
      send_data  = 8'h0F;
      rx_ready   = 1'b1;
      rx_data    = 8'h70;
      t = cyc + 1;
      push_trig(8'h8F, t);
      push_move(8'h70, t);
      push_trig(8'h0F, t + F + 1);
      step(1);
      send_valid = 1'b0;
      rx_ready   = 1'b0;
      step(5);
      rx_ready = 1'b1;
      rx_data  = 8'h11;
      step(1);
      rx_ready = 1'b0;
      step(t + 2 * F + 5 - cyc);
      rx_ready = 1'b1;
      rx_data  = 8'hF0;
      step(1);
      rx_ready = 1'b0;
      chk("t4_done", {31'd0, send_done}, 32'd1);
      chk("t4_move_hold", {24'd0, move_data}, 32'h70);
      step(1);

      // Wrong byte in WAIT_ACK is ignored; timeout still fires
      send_valid = 1'b1;
      send_data  = 8'h01;
      t = cyc + 1;
      push_trig(8'h01, t);
      push_trig(8'h01, t + PERIOD_GAP);
      step(1);
      send_valid = 1'b0;
      step(5);
      send_valid = 1'b1;
      send_data  = 8'h99;
      step(1);
      send_valid = 1'b0;
      step(t + F + 10 - cyc);
      rx_ready = 1'b1;
      rx_data  = 8'h01;
      step(1);
      rx_ready = 1'b0;
      chk("t5_no_done", {31'd0, send_done}, 32'd0);
      chk("t5_busy", {31'd0, send_busy}, 32'd1);
      step(t + PERIOD_GAP + F + 5 - cyc);
      rx_ready = 1'b1;
      rx_data  = 8'hFE;
      step(1);
      rx_ready = 1'b0;
      chk("t5_done", {31'd0, send_done}, 32'd1);
      chk("t5_busy_fall", {31'd0, send_busy}, 32'd0);
      step(F + 5);

      // Reset 10 cycles into SEND
      send_valid = 1'b1;
      send_data  = 8'h77;
      push_trig(8'h77, cyc + 1);
      step(1);
      send_valid = 1'b0;
      step(10);
      rst_in = 1'b1;
      #1;
      chk("t6_tx_data", {24'd0, tx_data}, 32'h00);
      chk("t6_move_data", {24'd0, move_data}, 32'h00);
      chk("t6_flags", {26'd0, send_busy, send_done, link_err, move_valid, tx_trigger, 1'b0}, 32'h0);
      step(2);
      rst_in = 1'b0;
      step(PERIOD_GAP * 2);

      chk("trig_q_empty", trig_q.size(), 32'd0);
      chk("move_q_empty", move_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/move_link.md
# move_link

Reliable move-exchange layer between the game FSM / user I/O and the UART `tx`/`rx` pair. Each outgoing move byte is transmitted and must be acknowledged by the peer echoing its bitwise complement; unacknowledged moves are retransmitted. Incoming move bytes are delivered once to the game FSM and always acknowledged. This block owns `tx` triggering, so `tx` and `rx` connect only through it.

## Interface
- `PKT_LEN`, 8, move/UART byte width.
- `TX_FRAME_CYCLES`, 67_710, clocks one UART frame occupies on `tx` (10 bits × DIVISOR 6771 at 65 MHz / 9600 baud).
- `ACK_TIMEOUT`, 650_000, clocks to wait for an ack after a frame finishes (10 ms at 65 MHz).
- `MAX_RETRY`, 3, retransmissions after the first attempt.

Ports:
- `clk_in` in 1: 65 MHz system clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `send_valid` in 1: one-cycle request to send `send_data` (game FSM `tx_ready`).
- `send_data` in PKT_LEN: move byte, sampled when `send_valid`=1.
- `send_busy` out 1: outgoing move in flight.
- `send_done` out 1: one-cycle pulse when the ack is received.
- `link_err` out 1: sticky, set when retries are exhausted.
- `tx_trigger` out 1: one-cycle start pulse to `tx`.
- `tx_data` out PKT_LEN: byte for `tx`, held stable for the whole frame.
- `rx_ready` in 1: one-cycle pulse from `rx`, byte valid on `rx_data`.
- `rx_data` in PKT_LEN: received byte.
- `move_valid` out 1: one-cycle pulse, new peer move on `move_data`.
- `move_data` out PKT_LEN: peer move, held until the next delivery.

## Operation
- States: IDLE, SEND (frame time for a move), WAIT_ACK, ACK (frame time for an ack).
- IDLE + `send_valid`:
  - latch `send_data` into `tx_data`;
  - pulse `tx_trigger`, set `send_busy`, clear `link_err`, clear retry count;
  - clear `last_valid`, since the turn has passed to us;
  - go to SEND.
- SEND: count TX_FRAME_CYCLES, then go to WAIT_ACK with the timer at 0.
- WAIT_ACK, `rx_ready` with `rx_data == ~tx_data`: pulse `send_done`, clear `send_busy`, go to IDLE.
- WAIT_ACK, any other byte: ignore it. No delivery, no ack, timer keeps running.
- WAIT_ACK timeout (timer reaches ACK_TIMEOUT):
  - if retries < MAX_RETRY: increment retries, re-pulse `tx_trigger` with the same `tx_data`, go to SEND;
  - else: set `link_err`, clear `send_busy`, go to IDLE.
- IDLE + `rx_ready` (byte b):
  - if `last_valid` and b == `last_rx` (duplicate caused by a lost ack): do not deliver;
  - else: `move_data`←b, pulse `move_valid`, `last_rx`←b, `last_valid`←1;
  - in both cases: `tx_data`←~b, pulse `tx_trigger`, go to ACK.
- ACK: count TX_FRAME_CYCLES, then go to IDLE.
- Simultaneous `send_valid` and `rx_ready` in IDLE: receive path wins. The send request is latched as pending (byte stored) and started on the IDLE cycle after ACK completes.
- `send_valid` while SEND/WAIT_ACK/ACK: stored as pending only in ACK. In SEND/WAIT_ACK it is dropped, since the FSM never sends twice per turn.
- `rx_ready` during SEND or ACK: ignored (half-duplex turn protocol).
- Counters: frame and timeout counters are 20-bit, saturating at their terminal value. Retry counter is `$clog2(MAX_RETRY+1)` bits.

## Timing
- Reset values:
  - all outputs 0 (`tx_data`, `move_data` = 8'h00);
  - state IDLE; `last_valid`=0; pending=0; all counters 0.
- Reset mid-frame aborts immediately. No further `tx_trigger`; `tx` is reset on the same line.
- `tx_trigger`: registered, asserted the cycle after the accepting `send_valid`/`rx_ready` edge (latency 1).
- `move_valid`: asserted in the same cycle as the ack's `tx_trigger`.
- Retransmit trigger: the cycle after the timer reaches ACK_TIMEOUT.
- Timing from the last `tx_trigger` of an attempt:
  - `send_done` latency: 1 cycle after the matching `rx_ready`;
  - `link_err` rises TX_FRAME_CYCLES + ACK_TIMEOUT + 1 cycles after that trigger.
- `tx_data` is never changed between a `tx_trigger` and the end of its frame count.

## Test plan
Bench uses TX_FRAME_CYCLES=20, ACK_TIMEOUT=100, MAX_RETRY=2.
- Send 8'h3C, peer returns 8'hC3 during WAIT_ACK:
  - one `tx_trigger` with `tx_data`=3C;
  - `send_done` pulses once, one cycle after `rx_ready`;
  - `send_busy` falls; `link_err`=0.
- Send 8'h12, no reply:
  - exactly 3 triggers, each 121 cycles apart, all with data 12;
  - `link_err`=1, 121 cycles after the third trigger.
- Receive 8'h55 in IDLE:
  - `move_valid` pulse with `move_data`=55;
  - `tx_trigger` with 8'hAA;
  - second 8'h55 after ACK: re-acked with AA, no `move_valid`;
  - local send, then another 55: delivered again.
- Simultaneous `send_valid`(8'h0F) and `rx_ready`(8'h70):
  - ack 8F sent first, 70 delivered;
  - 0F triggered on the cycle after ACK ends.
- In WAIT_ACK for 8'h01, a wrong byte 8'h01 arrives:
  - ignored, no delivery, timeout still fires on schedule;
  - a correct FE then completes.
- Assert `rst_in` 10 cycles into SEND:
  - all outputs 0 immediately;
  - no trigger afterwards until a new `send_valid`.
